// File: rtl/rv32i_types.sv
// Shared rv32i pipeline types, including the cache/memory arbiter
// state and requester encodings.
package rv32i_types;

    typedef logic [31:0]  rv32i_word;
    typedef logic [255:0] rv32i_line;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } arb_req_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// L1 cache and physical memory signals seen by the arbiter.
// slave = arbiter side, master = caches plus memory side.
interface cache_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);

    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport slave (
        input  i_read, i_address,
        input  d_read, d_write, d_address, d_wdata,
        input  pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output i_read, i_address,
        output d_read, d_write, d_address, d_wdata,
        output pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );

endinterface

// File: rtl/cache_mem_arbiter.sv
// Serialises icache/dcache line transactions onto one memory port.
// Define CACHE_ARB_RR_EN to alternate grants on a tie instead of dcache first.
module cache_mem_arbiter
    import rv32i_types::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input logic          clk,
    input logic          rst,
    cache_mem_arbiter_if.slave bus
);

    arb_state_t            state;
    arb_state_t            state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic                  write_q;

    logic d_req;
    logic tie_to_i;
    logic grant_i;
    logic grant_d;

    assign d_req = bus.d_read | bus.d_write;

`ifdef CACHE_ARB_RR_EN
    arb_req_t last_grant;

    assign tie_to_i = bus.i_read && d_req && (last_grant == REQ_D);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= REQ_I;
        end else if (grant_d) begin
            last_grant <= REQ_D;
        end else if (grant_i) begin
            last_grant <= REQ_I;
        end
    end
`else
    assign tie_to_i = 1'b0;
`endif

    assign grant_d = (state == IDLE) && d_req && !tie_to_i;
    assign grant_i = (state == IDLE) && bus.i_read && (!d_req || tie_to_i);

    // A dual read+write request is a writeback; the read half is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state <= state_next;
            if (grant_d) begin
                addr_q  <= bus.d_address;
                wdata_q <= bus.d_write ? bus.d_wdata : '0;
                write_q <= bus.d_write;
            end else if (grant_i) begin
                addr_q  <= bus.i_address;
                wdata_q <= '0;
                write_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next       = state;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        bus.i_resp       = 1'b0;
        bus.i_rdata      = '0;
        bus.d_resp       = 1'b0;
        bus.d_rdata      = '0;
        unique case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next = BUSY_D;
                end else if (grant_i) begin
                    state_next = BUSY_I;
                end
            end
            BUSY_I: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = addr_q;
                if (bus.pmem_resp) begin
                    bus.i_resp  = 1'b1;
                    bus.i_rdata = bus.pmem_rdata;
                    state_next  = DONE;
                end
            end
            BUSY_D: begin
                bus.pmem_read    = !write_q;
                bus.pmem_write   = write_q;
                bus.pmem_address = addr_q;
                bus.pmem_wdata   = wdata_q;
                if (bus.pmem_resp) begin
                    bus.d_resp  = 1'b1;
                    bus.d_rdata = bus.pmem_rdata;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: vector table, tie,
// mid-transaction reset and spurious-response sequences.
module tb_cache_mem_arbiter;
    import rv32i_types::*;

    localparam int AW = 32;
    localparam int LW = 256;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    cache_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          d;
        logic [LW-1:0] data;
    } resp_t;

    resp_t sb[$];

    typedef struct {
        logic          ir;
        logic          dr;
        logic          dw;
        logic [AW-1:0] ia;
        logic [AW-1:0] da;
        logic [LW-1:0] wd;
        int            lat;
        logic [LW-1:0] rd;
        logic          ex_d;
        logic          ex_rd;
        logic          ex_wr;
        logic [AW-1:0] ex_a;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input string tag);
        chk({tag, "_ctl"},
            {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}, '0);
        chk({tag, "_rdata"}, bus.i_rdata | bus.d_rdata, '0);
    endtask

    // Called at the start of an IDLE cycle with requests already driven.
    // Returns at the start of the IDLE cycle after DONE.
    task automatic serve(input logic ex_d, input logic ex_rd,
                         input logic ex_wr, input logic [AW-1:0] ex_a,
                         input logic [LW-1:0] ex_wd, input int lat,
                         input logic [LW-1:0] rd, input logic drop_i,
                         input logic drop_d, input logic [AW-1:0] scr);
        resp_t e;
        @(negedge clk);
        quiet("idle_req");
        sb.push_back('{ex_d, rd});
        for (int c = 1; c <= lat; c++) begin
            tick();
            bus.pmem_rdata = {8{$urandom()}};
            if (c == lat) begin
                bus.pmem_resp  = 1'b1;
                bus.pmem_rdata = rd;
            end
            if (scr != '0 && c == 1) begin
                bus.d_address = scr;
                bus.d_wdata   = ~bus.d_wdata;
            end
            @(negedge clk);
            chk("strobes", {bus.pmem_read, bus.pmem_write}, {ex_rd, ex_wr});
            chk("pmem_address", bus.pmem_address, ex_a);
            if (ex_wr) chk("pmem_wdata", bus.pmem_wdata, ex_wd);
            if (c == lat) begin
                chk("resp", {bus.i_resp, bus.d_resp}, {!ex_d, ex_d});
                chk("loser_rdata", ex_d ? bus.i_rdata : bus.d_rdata, '0);
                if (bus.i_resp || bus.d_resp) begin
                    e = sb.pop_front();
                    chk("sb_rdata", e.d ? bus.d_rdata : bus.i_rdata, e.data);
                end
            end else begin
                chk("resp_early", {bus.i_resp, bus.d_resp}, '0);
                chk("rdata_early", bus.i_rdata | bus.d_rdata, '0);
            end
        end
        tick();
        bus.pmem_resp = 1'b1;
        if (drop_i) bus.i_read = 1'b0;
        if (drop_d) begin
            bus.d_read  = 1'b0;
            bus.d_write = 1'b0;
        end
        @(negedge clk);
        quiet("done");
        tick();
        bus.pmem_resp = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h999, 256'h0, 5,
                    {32{8'hA5}}, 1'b0, 1'b1, 1'b0, 32'h40};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h777, 32'h1000, {16{16'h1234}}, 3,
                    {8{32'h55AA55AA}}, 1'b1, 1'b0, 1'b1, 32'h1000};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h2000, {8{32'h11111111}}, 1,
                    {8{32'hDEADBEEF}}, 1'b1, 1'b1, 1'b0, 32'h2000};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h3000, {8{32'hCAFEF00D}}, 2,
                    {8{32'h0BAD0BAD}}, 1'b1, 1'b0, 1'b1, 32'h3000};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFC0, 32'h0, 256'h0, 2,
                    {4{64'h0123456789ABCDEF}}, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFC0};

        rst            = 1'b1;
        bus.i_read     = 1'b0;
        bus.i_address  = '0;
        bus.d_read     = 1'b0;
        bus.d_write    = 1'b0;
        bus.d_address  = '0;
        bus.d_wdata    = '0;
        bus.pmem_rdata = '0;
        bus.pmem_resp  = 1'b0;

        tick();
        tick();
        @(negedge clk);
        quiet("reset");
        chk("reset_addr", bus.pmem_address, '0);
        chk("reset_wdata", bus.pmem_wdata, '0);
        chk("reset_state", dut.state, IDLE);

        tick();
        rst            = 1'b0;
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = {8{32'hBADBAD00}};
        @(negedge clk);
        quiet("spurious_idle0");
        tick();
        @(negedge clk);
        quiet("spurious_idle1");
        tick();
        bus.pmem_resp = 1'b0;

        foreach (vecs[k]) begin
            bus.i_read    = vecs[k].ir;
            bus.i_address = vecs[k].ia;
            bus.d_read    = vecs[k].dr;
            bus.d_write   = vecs[k].dw;
            bus.d_address = vecs[k].da;
            bus.d_wdata   = vecs[k].wd;
            serve(vecs[k].ex_d, vecs[k].ex_rd, vecs[k].ex_wr, vecs[k].ex_a,
                  vecs[k].wd, vecs[k].lat, vecs[k].rd, 1'b1, 1'b1, '0);
        end

        // Tie: dcache wins first; its address moves to 0x200 while busy.
        bus.i_read    = 1'b1;
        bus.i_address = 32'h80;
        bus.d_read    = 1'b1;
        bus.d_address = 32'h100;
        serve(1'b1, 1'b1, 1'b0, 32'h100, '0, 2, {8{32'hD1D1D1D1}},
              1'b0, 1'b0, 32'h200);
`ifdef CACHE_ARB_RR_EN
        serve(1'b0, 1'b1, 1'b0, 32'h80, '0, 1, {8{32'h1C1C1C1C}},
              1'b1, 1'b0, '0);
        serve(1'b1, 1'b1, 1'b0, 32'h200, '0, 1, {8{32'hD2D2D2D2}},
              1'b0, 1'b1, '0);
`else
        serve(1'b1, 1'b1, 1'b0, 32'h200, '0, 1, {8{32'hD2D2D2D2}},
              1'b0, 1'b1, '0);
        serve(1'b0, 1'b1, 1'b0, 32'h80, '0, 1, {8{32'h1C1C1C1C}},
              1'b1, 1'b0, '0);
`endif

        // Reset while BUSY_I, then a late memory response.
        bus.i_read    = 1'b1;
        bus.i_address = 32'h300;
        @(negedge clk);
        quiet("rst_idle");
        tick();
        @(negedge clk);
        chk("rst_busy_strobe", {bus.pmem_read, bus.pmem_write}, 2'b10);
        chk("rst_busy_addr", bus.pmem_address, 32'h300);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_sync_strobe", {bus.pmem_read, bus.pmem_write}, 2'b10);
        tick();
        rst            = 1'b0;
        bus.i_read     = 1'b0;
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = {8{32'h1A7E1A7E}};
        @(negedge clk);
        quiet("after_rst");
        chk("after_rst_state", dut.state, IDLE);
        tick();
        @(negedge clk);
        quiet("late_resp");
        tick();
        bus.pmem_resp = 1'b0;

        bus.d_read    = 1'b1;
        bus.d_address = 32'h400;
        serve(1'b1, 1'b1, 1'b0, 32'h400, '0, 1, {8{32'h0F0F0F0F}},
              1'b1, 1'b1, '0);

        chk("sb_empty", sb.size(), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares one physical memory line port between the instruction cache and the data cache of the rv32i pipeline.
- Serialises line reads and writebacks: one outstanding transaction at a time.
- Latches the winning request and forwards the memory response to the winner only.
- Sits between the L1 caches and the physical memory model or burst adapter.

Parameters:
- ADDR_WIDTH, 32, byte address width (rv32i_word).
- LINE_WIDTH, 256, cache line width in bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_read  in  1  icache line read request.
- i_address  in  ADDR_WIDTH  icache line address.
- i_rdata  out  LINE_WIDTH  line data returned to icache.
- i_resp  out  1  icache transaction complete.
- d_read  in  1  dcache line read request.
- d_write  in  1  dcache line writeback request.
- d_address  in  ADDR_WIDTH  dcache line address.
- d_wdata  in  LINE_WIDTH  dcache writeback data.
- d_rdata  out  LINE_WIDTH  line data returned to dcache.
- d_resp  out  1  dcache transaction complete.
- pmem_read  out  1  memory read strobe.
- pmem_write  out  1  memory write strobe.
- pmem_address  out  ADDR_WIDTH  memory line address.
- pmem_wdata  out  LINE_WIDTH  memory write data.
- pmem_rdata  in  LINE_WIDTH  memory read data.
- pmem_resp  in  1  memory transaction complete.

Behaviour:
- States (arb_state_t): IDLE, BUSY_I, BUSY_D, DONE.
- Reset (clk edge with rst=1):
  - state=IDLE; latched addr/wdata/op cleared to 0; last_grant=REQ_I.
  - All outputs 0: pmem_read, pmem_write, i_resp, d_resp, pmem_address, pmem_wdata.
  - i_rdata and d_rdata are 0 while their resp is low.
- IDLE, grant rule:
  - Fixed priority: dcache wins if (d_read|d_write); otherwise icache if i_read.
  - On grant, latch address, op and wdata (dcache) at the clk edge; move to BUSY_D or BUSY_I.
  - No pmem strobes are driven in IDLE.
- BUSY_x:
  - pmem_read (or pmem_write for a dcache write) is asserted continuously from the cycle after the grant, driven from latched registers.
  - Requester inputs are ignored while busy; changing them has no effect.
- Response cycle:
  - In the cycle pmem_resp=1, x_resp=1 combinationally.
  - x_rdata = pmem_rdata in that same cycle.
  - Next state DONE.
- DONE: one cycle with no strobes and no grant, so the requester can drop its request; then IDLE.
- Minimum latency: request at cycle t, strobe at t+1, resp at the pmem_resp cycle (>= t+1). Back-to-back grants are spaced by at least 1 idle cycle (DONE) plus 1 IDLE cycle.
- d_read and d_write both high: treated as a write; the read is ignored.
- pmem_resp while in IDLE or DONE: ignored; no resp forwarded.
- Reset mid-transaction: strobes drop at the next edge; no resp is forwarded; the latched request is discarded.
- Non-winning resp output and rdata stay 0 at all times.

Optional Feature:
- Macro: CACHE_ARB_RR_EN.
- Defined:
  - When both caches request in IDLE, grant the requester that is not last_grant.
  - last_grant updates on every grant; after reset dcache wins the first tie.
  - A single requester is always granted immediately.
- Undefined: fixed dcache priority; last_grant register is not built.

Decomposition:
- Add to the shared rv32i_types package:
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D, DONE}.
  - arb_req_t enum {REQ_I, REQ_D}.
  - Typedef rv32i_line as logic [255:0].
- No sub-module is warranted. FSM, request latch and output mux stay in one module (~150 lines).

Test Plan:
- Single icache read, addr 0x0000_0040, memory resp after 5 cycles with data 0xA5 repeated:
  - pmem_read high cycles t+1..t+5; pmem_address=0x40.
  - i_resp=1 for exactly 1 cycle with i_rdata=0xA5..A5; d_resp stays 0.
- Dcache write, addr 0x0000_1000, wdata 0x1234 pattern:
  - pmem_write=1, pmem_read=0; pmem_wdata matches.
  - d_resp pulses once; DONE cycle shows no strobes.
- Simultaneous i_read(0x80) and d_read(0x100), fixed priority:
  - dcache served first; icache is served second after a >=2-cycle gap.
  - With CACHE_ARB_RR_EN, a second tie after a D grant is won by I.
- Requester changes address during BUSY_D (0x100 to 0x200): pmem_address stays 0x100 throughout.
- Reset asserted mid-BUSY_I:
  - Next cycle all strobes and resps are 0 and state is IDLE.
  - A late pmem_resp=1 produces no i_resp.
- Spurious pmem_resp in IDLE, plus d_read & d_write both high:
  - The spurious resp is ignored.
  - The dual request issues only pmem_write.
